// File: rtl/synchronization.sv
// 1000BASE-X PCS receive code-group synchronization.
// Finds K28.5 alignment, labels groups even/odd, reports sync_status.
module synchronization (
   input  logic       clk,
   input  logic       mr_main_reset,
   input  logic [9:0] rx_code_group,
   input  logic       signal_detect,
   output logic [9:0] SUDI,
   output logic       EVEN,
   output logic       sync_status
);

   // Running-disparity-negative encodings, bits abcdei_fghj
   localparam logic [9:0] D00_0 = 10'b100111_0100;
   localparam logic [9:0] D01_0 = 10'b011101_0100;
   localparam logic [9:0] D02_0 = 10'b101101_0100;
   localparam logic [9:0] D03_0 = 10'b110001_1011;
   localparam logic [9:0] D02_2 = 10'b101101_0101;
   localparam logic [9:0] D16_2 = 10'b011011_0101;
   localparam logic [9:0] D26_4 = 10'b010110_1101;
   localparam logic [9:0] D06_5 = 10'b011001_1010;
   localparam logic [9:0] D21_5 = 10'b101010_1010;
   localparam logic [9:0] D05_6 = 10'b101001_0110;
   localparam logic [9:0] K28_5 = 10'b001111_1010;
   localparam logic [9:0] K23_7 = 10'b111010_1000;
   localparam logic [9:0] K27_7 = 10'b110110_1000;
   localparam logic [9:0] K29_7 = 10'b101110_1000;

   typedef enum logic [3:0] {
      LOSS_OF_SYNC,
      COMMA_DETECT_1,
      COMMA_DETECT_2,
      COMMA_DETECT_3,
      ACQUIRE_SYNC_1,
      ACQUIRE_SYNC_2,
      SYNC_ACQUIRED_1,
      SYNC_ACQUIRED_2,
      SYNC_ACQUIRED_2A,
      SYNC_ACQUIRED_3,
      SYNC_ACQUIRED_3A,
      SYNC_ACQUIRED_4,
      SYNC_ACQUIRED_4A
   } state_t;

   state_t     state, state_nxt;
   logic       rx_even, even_nxt;
   logic [1:0] good_cgs, good_nxt;
   logic       sync_nxt;
   logic       comma, data, valid, cgbad;

   always_comb begin
      comma = (rx_code_group == K28_5);
      data  = rx_code_group inside {
         D00_0, D01_0, D02_0, D03_0, D02_2,
         D16_2, D26_4, D06_5, D21_5, D05_6};
      valid = data | comma |
              (rx_code_group inside {K23_7, K27_7, K29_7});
      cgbad = !valid | (comma & rx_even);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOSS_OF_SYNC:
            if (comma) state_nxt = COMMA_DETECT_1;
         COMMA_DETECT_1:
            state_nxt = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
         COMMA_DETECT_2:
            state_nxt = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
         COMMA_DETECT_3:
            state_nxt = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
         ACQUIRE_SYNC_1:
            if (cgbad) state_nxt = LOSS_OF_SYNC;
            else if (comma && !rx_even) state_nxt = COMMA_DETECT_2;
         ACQUIRE_SYNC_2:
            if (cgbad) state_nxt = LOSS_OF_SYNC;
            else if (comma && !rx_even) state_nxt = COMMA_DETECT_3;
         SYNC_ACQUIRED_1:
            if (cgbad) state_nxt = SYNC_ACQUIRED_2;
         SYNC_ACQUIRED_2:
            state_nxt = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
         SYNC_ACQUIRED_2A:
            if (cgbad) state_nxt = SYNC_ACQUIRED_3;
            else if (good_cgs == 2'd3) state_nxt = SYNC_ACQUIRED_1;
         SYNC_ACQUIRED_3:
            state_nxt = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
         SYNC_ACQUIRED_3A:
            if (cgbad) state_nxt = SYNC_ACQUIRED_4;
            else if (good_cgs == 2'd3) state_nxt = SYNC_ACQUIRED_2;
         SYNC_ACQUIRED_4:
            state_nxt = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
         SYNC_ACQUIRED_4A:
            if (cgbad) state_nxt = LOSS_OF_SYNC;
            else if (good_cgs == 2'd3) state_nxt = SYNC_ACQUIRED_3;
         default:
            state_nxt = LOSS_OF_SYNC;
      endcase
      if (!signal_detect) state_nxt = LOSS_OF_SYNC;
   end

   // Entry actions fire on every edge, self-loops included
   always_comb begin
      even_nxt = !rx_even;
      good_nxt = good_cgs;
      unique case (1'b1)
         state_nxt inside {COMMA_DETECT_1, COMMA_DETECT_2,
                           COMMA_DETECT_3}:
            even_nxt = 1'b1;
         state_nxt inside {SYNC_ACQUIRED_2, SYNC_ACQUIRED_3,
                           SYNC_ACQUIRED_4}:
            good_nxt = 2'd0;
         state_nxt inside {SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A,
                           SYNC_ACQUIRED_4A}:
            good_nxt = (good_cgs == 2'd3) ? 2'd3 : good_cgs + 2'd1;
         default: ;
      endcase
      sync_nxt = state_nxt inside {
         SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
         SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
         SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
   end

   always_ff @(posedge clk or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state       <= LOSS_OF_SYNC;
         rx_even     <= 1'b0;
         good_cgs    <= 2'd0;
         SUDI        <= 10'b0;
         sync_status <= 1'b0;
      end else begin
         state       <= state_nxt;
         rx_even     <= even_nxt;
         good_cgs    <= good_nxt;
         SUDI        <= rx_code_group;
         sync_status <= sync_nxt;
      end
   end

   assign EVEN = rx_even;

endmodule

// File: tb/tb_synchronization.sv
// Randomized scoreboard bench for synchronization.
// Reference model counts commas, errors and good runs.
module tb_synchronization;

   localparam logic [9:0] K285 = 10'b001111_1010;
   localparam logic [9:0] D162 = 10'b011011_0101;
   localparam logic [9:0] BAD  = 10'h000;

   logic       clk = 1'b0;
   logic       mr_main_reset = 1'b0;
   logic [9:0] rx_code_group = 10'h0;
   logic       signal_detect = 1'b1;
   logic [9:0] SUDI;
   logic       EVEN;
   logic       sync_status;

   synchronization dut (
      .clk           (clk),
      .mr_main_reset (mr_main_reset),
      .rx_code_group (rx_code_group),
      .signal_detect (signal_detect),
      .SUDI          (SUDI),
      .EVEN          (EVEN),
      .sync_status   (sync_status)
   );

   always #5 clk = ~clk;

   logic [9:0] data_tbl [10] = '{
      10'b100111_0100, 10'b011101_0100, 10'b101101_0100,
      10'b110001_1011, 10'b101101_0101, 10'b011011_0101,
      10'b010110_1101, 10'b011001_1010, 10'b101010_1010,
      10'b101001_0110};
   logic [9:0] ctrl_tbl [4] = '{
      10'b001111_1010, 10'b111010_1000,
      10'b110110_1000, 10'b101110_1000};

   typedef struct {
      logic [9:0] sudi;
      logic       even;
      logic       sync;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // mode: 0 lost, 1 comma seen, 2 acquiring, 3 synced
   int m_mode, m_commas, m_err, m_run;
   bit m_even;

   task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit in_tbl_d(logic [9:0] c);
      foreach (data_tbl[i]) if (data_tbl[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit in_tbl_k(logic [9:0] c);
      foreach (ctrl_tbl[i]) if (ctrl_tbl[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_commas = 0; m_err = 0; m_run = 0;
      m_even = 1'b0;
   endtask

   task automatic model_step(logic [9:0] c, bit sd);
      bit pe, isc, dat, bad;
      pe  = m_even;
      isc = (c == K285);
      dat = in_tbl_d(c);
      bad = !(dat || in_tbl_k(c)) || (isc && pe);
      m_even = !m_even;
      if (!sd) begin
         m_mode = 0;
         return;
      end
      case (m_mode)
         0: if (isc) begin
               m_mode = 1; m_commas = 1; m_even = 1'b1;
            end
         1: if (!dat) m_mode = 0;
            else if (m_commas == 3) begin
               m_mode = 3; m_err = 0; m_run = 0;
            end else m_mode = 2;
         2: if (bad) m_mode = 0;
            else if (isc && !pe) begin
               m_mode = 1; m_commas++; m_even = 1'b1;
            end
         default:
            if (bad) begin
               if (m_err == 3) m_mode = 0;
               else begin m_err++; m_run = 0; end
            end else if (m_err > 0) begin
               m_run++;
               if (m_run == 4) begin m_err--; m_run = 0; end
            end
      endcase
   endtask

   // Called at a negedge; leaves the bench at the following negedge
   task automatic drive(logic [9:0] c, bit sd);
      exp_t e;
      rx_code_group = c;
      signal_detect = sd;
      model_step(c, sd);
      e.sudi = c;
      e.even = m_even;
      e.sync = (m_mode == 3);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic acquire();
      repeat (3) begin
         drive(K285, 1'b1);
         drive(D162, 1'b1);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sudi", SUDI, e.sudi);
            chk("even", {9'b0, EVEN}, {9'b0, e.even});
            chk("sync", {9'b0, sync_status}, {9'b0, e.sync});
         end
      end
   end

   initial begin
      int n;
      logic [9:0] c;
      bit sd;
      model_reset();
      rx_code_group = K285;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_sudi", SUDI, 10'h0);
         chk("rst_even", {9'b0, EVEN}, 10'h0);
         chk("rst_sync", {9'b0, sync_status}, 10'h0);
      end
      @(negedge clk);
      mr_main_reset = 1'b1;
      acquire();
      chk("acq_sync", {9'b0, sync_status}, 10'h1);

      drive(D162, 1'b1);
      drive(K285, 1'b1);
      repeat (4) drive(D162, 1'b1);
      drive(D162, 1'b1);
      drive(K285, 1'b1);
      drive(D162, 1'b1);
      drive(BAD, 1'b1);
      repeat (12) drive(D162, 1'b1);

      repeat (4) drive(BAD, 1'b1);
      drive(K285, 1'b1);
      drive(D162, 1'b1);
      drive(BAD, 1'b1);

      acquire();
      drive(D162, 1'b0);
      drive(D162, 1'b1);
      acquire();

      for (int i = 0; i < 600; i++) begin
         if (i % 2 == 0 && $urandom_range(0, 9) != 0) c = K285;
         else c = data_tbl[$urandom_range(0, 9)];
         if ($urandom_range(0, 99) < 4) c = 10'($urandom);
         if ($urandom_range(0, 99) < 3)
            c = ctrl_tbl[$urandom_range(0, 3)];
         sd = ($urandom_range(0, 99) > 1);
         drive(c, sd);
      end

      drive(D162, 1'b0);
      acquire();
      chk("pre_rst_sync", {9'b0, sync_status}, 10'h1);
      #2 mr_main_reset = 1'b0;
      #1;
      chk("async_sudi", SUDI, 10'h0);
      chk("async_even", {9'b0, EVEN}, 10'h0);
      chk("async_sync", {9'b0, sync_status}, 10'h0);
      model_reset();
      @(negedge clk);
      mr_main_reset = 1'b1;
      acquire();
      repeat (3) drive(D162, 1'b1);

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      #2;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
